// File: rtl/pwm_brightness_gen.sv
// Single-channel PWM generator: period/duty in clock cycles, 8-bit brightness
// scaling of the duty, selectable output polarity, registered output.
module pwm_brightness_gen #(
    parameter int CNT_W    = 32,
    parameter int BRIGHT_W = 8
) (
    input  logic                i_sysclk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_polar,
    input  logic [CNT_W-1:0]    i_freq_cnt,
    input  logic [CNT_W-1:0]    i_duty_cnt,
    input  logic [BRIGHT_W-1:0] i_brightness,
    output logic                o_pwm_out
);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          per_sh_q, per_sh_d;
    logic [CNT_W-1:0]          eff_sh_q, eff_sh_d;
    logic                      out_q, out_d;
    logic [CNT_W+BRIGHT_W-1:0] prod;
    logic [CNT_W-1:0]          eff_calc;
    logic                      load;

    always_comb begin
        prod = {{BRIGHT_W{1'b0}}, i_duty_cnt} * {{CNT_W{1'b0}}, i_brightness};
        // Full-scale brightness passes duty through unscaled instead of duty*255/256.
        if (i_brightness == '1) begin
            eff_calc = i_duty_cnt;
        end else begin
            eff_calc = prod[CNT_W+BRIGHT_W-1:BRIGHT_W];
        end
    end

    // The counter sits at 0 while disabled, so the first enabled clock and
    // every period start share one reload condition.
    always_comb begin
        load     = i_enable && (cnt_q == '0);
        per_sh_d = load ? i_freq_cnt : per_sh_q;
        eff_sh_d = load ? eff_calc   : eff_sh_q;
        cnt_d    = '0;
        out_d    = i_polar;
        if (i_enable) begin
            if ((per_sh_d != '0) && (cnt_q < eff_sh_d)) begin
                out_d = ~i_polar;
            end
            if ((per_sh_d > CNT_W'(1)) && (cnt_q < per_sh_d - CNT_W'(1))) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            per_sh_q <= '0;
            eff_sh_q <= '0;
            out_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            per_sh_q <= per_sh_d;
            eff_sh_q <= eff_sh_d;
            out_q    <= out_d;
        end
    end

    assign o_pwm_out = out_q;

endmodule

// File: tb/tb_pwm_brightness_gen.sv
// Directed bench for pwm_brightness_gen: pulse widths, polarity, enable,
// brightness scaling, period reload timing and boundary cases.
module tb_pwm_brightness_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        pol;
    logic [31:0] freq;
    logic [31:0] duty;
    logic [7:0]  bri;
    logic        pwm;

    int n_assert = 0;
    int n_fail   = 0;
    int len;
    int cnt;

    pwm_brightness_gen #(
        .CNT_W    (32),
        .BRIGHT_W (8)
    ) dut (
        .i_sysclk     (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_polar      (pol),
        .i_freq_cnt   (freq),
        .i_duty_cnt   (duty),
        .i_brightness (bri),
        .o_pwm_out    (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Length of the current run of 'lvl' on the output, bounded.
    task automatic run_len(input logic lvl, input int bound, output int n);
        n = 0;
        while ((pwm === lvl) && (n < bound)) begin
            n++;
            tick();
        end
    endtask

    // Number of samples at 'lvl' over the next 'win' cycles.
    task automatic count_level(input logic lvl, input int win, output int n);
        n = 0;
        for (int i = 0; i < win; i++) begin
            if (pwm === lvl) n++;
            tick();
        end
    endtask

    task automatic restart(input logic [31:0] f, input logic [31:0] d, input logic [7:0] b);
        en = 1'b0;
        tick();
        freq = f;
        duty = d;
        bri  = b;
        en   = 1'b1;
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        pol  = 1'b0;
        freq = '0;
        duty = '0;
        bri  = '0;
        #3;
        check("reset_out", {63'd0, pwm}, 64'd0);
        #32;
        rst = 1'b0;
        tick();
        check("idle_after_reset", {63'd0, pwm}, 64'd0);

        // 16384-clock period, duty 8192 at half brightness -> 4096 active
        freq = 32'd16384;
        duty = 32'd8192;
        bri  = 8'd128;
        en   = 1'b1;
        tick();
        check("first_active", {63'd0, pwm}, 64'd1);
        run_len(1'b1, 20000, len);
        check("s2_high_len", 64'(len), 64'd4096);
        run_len(1'b0, 20000, len);
        check("s2_low_len", 64'(len), 64'd12288);

        en = 1'b0;
        tick();
        check("disable_idle", {63'd0, pwm}, 64'd0);
        check("disable_cnt", 64'(dut.cnt_q), 64'd0);
        count_level(1'b1, 3277, cnt);
        check("disable_hold", 64'(cnt), 64'd0);

        // Active-low polarity
        pol = 1'b1;
        en  = 1'b1;
        tick();
        check("pol_first", {63'd0, pwm}, 64'd0);
        run_len(1'b0, 20000, len);
        check("pol_low_len", 64'(len), 64'd4096);
        run_len(1'b1, 20000, len);
        check("pol_high_len", 64'(len), 64'd12288);
        en = 1'b0;
        tick();
        check("pol_idle", {63'd0, pwm}, 64'd1);
        pol = 1'b0;
        tick();
        check("polar_immediate", {63'd0, pwm}, 64'd0);

        // Brightness scaling over two 200-clock periods
        restart(32'd200, 32'd100, 8'd255);
        count_level(1'b1, 400, cnt);
        check("bright255", 64'(cnt), 64'd200);
        restart(32'd200, 32'd100, 8'd128);
        count_level(1'b1, 400, cnt);
        check("bright128", 64'(cnt), 64'd100);
        restart(32'd200, 32'd100, 8'd200);
        count_level(1'b1, 400, cnt);
        check("bright200", 64'(cnt), 64'd156);
        restart(32'd200, 32'd100, 8'd0);
        count_level(1'b1, 400, cnt);
        check("bright0", 64'(cnt), 64'd0);
        restart(32'd100, 32'd20000, 8'd255);
        count_level(1'b1, 400, cnt);
        check("duty_ge_period", 64'(cnt), 64'd400);
        restart(32'd1, 32'd1, 8'd255);
        count_level(1'b1, 50, cnt);
        check("per1_active", 64'(cnt), 64'd50);
        restart(32'd1, 32'd0, 8'd255);
        count_level(1'b1, 50, cnt);
        check("per1_duty0", 64'(cnt), 64'd0);
        restart(32'd0, 32'd50, 8'd255);
        count_level(1'b1, 50, cnt);
        check("per0_idle", 64'(cnt), 64'd0);
        check("per0_cnt", 64'(dut.cnt_q), 64'd0);

        // Mid-period changes apply only at the next period start
        restart(32'd2000, 32'd1000, 8'd255);
        run_len(1'b1, 5000, len);
        check("mid_high_old", 64'(len), 64'd1000);
        freq = 32'd300;
        duty = 32'd100;
        run_len(1'b0, 5000, len);
        check("mid_low_old", 64'(len), 64'd1000);
        run_len(1'b1, 5000, len);
        check("new_high", 64'(len), 64'd100);
        run_len(1'b0, 5000, len);
        check("new_low", 64'(len), 64'd200);
        run_len(1'b1, 5000, len);
        check("new_high2", 64'(len), 64'd100);
        freq = 32'd0;
        count_level(1'b1, 500, cnt);
        check("freq0_idle", 64'(cnt), 64'd0);

        // Asynchronous reset while the inverted output sits idle-high
        pol = 1'b1;
        restart(32'd100, 32'd10, 8'd255);
        for (int i = 0; i < 20; i++) tick();
        check("pre_reset_idle_hi", {63'd0, pwm}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_out", {63'd0, pwm}, 64'd0);
        check("async_reset_cnt", 64'(dut.cnt_q), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post_reset_active", {63'd0, pwm}, 64'd0);
        tick();
        check("post_reset_cnt", 64'(dut.cnt_q), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
